// File: rtl/decode_control_pipe_pkg.sv
// Shared types and encodings for the RV32I(M) decode stage and its E-stage register.
// Opcodes, ALU/MDU operation codes, ImmSrc/ResultSrc encodings and the control bundle.
package decode_pkg;

  localparam int ALU_CTRL_W = 5;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_op_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MEM   = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;
  localparam logic [1:0] RES_PCIMM = 2'b11;

  // funct3 value 010 is unused by branches, so it marks "not a branch"
  localparam logic [2:0] BRANCH_NONE = 3'b010;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] branch;
    logic       jump;
    alu_op_t    alu_ctrl;
    logic       illegal;
  } ctrl_bundle_t;

  function automatic ctrl_bundle_t bubble_ctrl();
    ctrl_bundle_t b;
    b            = '0;
    b.branch     = BRANCH_NONE;
    b.alu_ctrl   = ADD;
    return b;
  endfunction

  // Base integer op for funct3, shared by register and immediate forms
  function automatic alu_op_t base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ADD;
      3'b001:  return SLL;
      3'b010:  return SLT;
      3'b011:  return SLTU;
      3'b100:  return XOR;
      3'b101:  return SRL;
      3'b110:  return OR;
      default: return AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_control_pipe_control_decode.sv
// Combinational opcode/funct decode into the control bundle plus ImmSrc.
// Invalid slots and unsupported encodings both yield a no-write bubble; only the latter flags illegal.
module control_decode
  import decode_pkg::*;
#(
  parameter bit SUPPORT_M = 1'b1
) (
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  input  logic         valid,
  output ctrl_bundle_t ctrl,
  output logic [2:0]   imm_src,
  output logic         is_div
);

  ctrl_bundle_t raw;
  logic [2:0]   raw_imm;
  logic         raw_div;
  logic         legal;

  always_comb begin
    raw     = bubble_ctrl();
    raw_imm = IMM_I;
    raw_div = 1'b0;
    legal   = 1'b1;
    case (opcode)
      OP: begin
        raw.reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          raw.alu_ctrl = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          raw.alu_ctrl = SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          raw.alu_ctrl = SRA;
        end else if (funct7 == F7_MULDIV && SUPPORT_M) begin
          case (funct3)
            3'b000:  raw.alu_ctrl = MUL;
            3'b001:  raw.alu_ctrl = MULH;
            3'b010:  raw.alu_ctrl = MULHSU;
            3'b011:  raw.alu_ctrl = MULHU;
            3'b100:  raw.alu_ctrl = DIV;
            3'b101:  raw.alu_ctrl = DIVU;
            3'b110:  raw.alu_ctrl = REM;
            default: raw.alu_ctrl = REMU;
          endcase
          raw_div = funct3[2];
        end else begin
          legal = 1'b0;
        end
      end
      OP_IMM: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.alu_ctrl  = base_op(funct3);
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) raw.alu_ctrl = SRA;
          else if (funct7 != F7_BASE) legal = 1'b0;
        end
      end
      LOAD: begin
        raw.reg_write  = 1'b1;
        raw.alu_src    = 1'b1;
        raw.result_src = RES_MEM;
        legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      STORE: begin
        raw.mem_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw_imm       = IMM_S;
        legal = (funct3[2] == 1'b0) && (funct3 != 3'b011);
      end
      BRANCH: begin
        // comparison is done by the ALU subtractor
        raw.branch   = funct3;
        raw.alu_ctrl = SUB;
        raw_imm      = IMM_B;
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      JAL: begin
        raw.reg_write  = 1'b1;
        raw.jump       = 1'b1;
        raw.result_src = RES_PC4;
        raw_imm        = IMM_J;
      end
      JALR: begin
        raw.reg_write  = 1'b1;
        raw.jump       = 1'b1;
        raw.alu_src    = 1'b1;
        raw.result_src = RES_PC4;
        legal = (funct3 == 3'b000);
      end
      LUI: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.alu_ctrl  = PASSB;
        raw_imm       = IMM_U;
      end
      AUIPC: begin
        raw.reg_write  = 1'b1;
        raw.alu_src    = 1'b1;
        raw.result_src = RES_PCIMM;
        raw_imm        = IMM_U;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    ctrl    = bubble_ctrl();
    imm_src = IMM_I;
    is_div  = 1'b0;
    if (valid && legal) begin
      ctrl    = raw;
      imm_src = raw_imm;
      is_div  = raw_div;
    end else if (valid) begin
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_control_pipe.sv
// Decode-stage control unit: D-stage decode, E-stage control register with hold/flush,
// and a divide sequencer that freezes E and stalls the front end for multi-cycle divides.
module decode_control_pipe
  import decode_pkg::*;
#(
  parameter bit SUPPORT_M  = 1'b1,
  parameter int DIV_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  valid_d,
  input  logic                  hold_e,
  input  logic                  flush_e,
  output logic [2:0]            ImmSrcD,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic [2:0]            BranchE,
  output logic                  JumpE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  illegal_e,
  output logic                  stall_req
);

  typedef enum logic {IDLE, BUSY} div_state_t;

  localparam bit         DIV_MULTI = (DIV_CYCLES > 1);
  localparam logic [3:0] CNT_INIT  = DIV_MULTI ? 4'(DIV_CYCLES - 2) : 4'd0;

  ctrl_bundle_t ctrl_d;
  logic         is_div_d;
  ctrl_bundle_t e_reg;
  div_state_t   state_reg;
  logic [3:0]   cnt_reg;

  control_decode #(.SUPPORT_M(SUPPORT_M)) u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .valid   (valid_d),
    .ctrl    (ctrl_d),
    .imm_src (ImmSrcD),
    .is_div  (is_div_d)
  );

  // cnt counts the remaining BUSY cycles after the current one
  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!hold_e && is_div_d && DIV_MULTI) begin
            state_reg <= BUSY;
            cnt_reg   <= CNT_INIT;
          end
        end
        default: begin
          if (cnt_reg == 4'd0) state_reg <= IDLE;
          else cnt_reg <= cnt_reg - 4'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      e_reg <= bubble_ctrl();
    end else if (state_reg == IDLE && !hold_e) begin
      e_reg <= ctrl_d;
    end
  end

  assign RegWriteE   = e_reg.reg_write;
  assign ResultSrcE  = e_reg.result_src;
  assign MemWriteE   = e_reg.mem_write;
  assign ALUSrcE     = e_reg.alu_src;
  assign BranchE     = e_reg.branch;
  assign JumpE       = e_reg.jump;
  assign ALUControlE = e_reg.alu_ctrl;
  assign illegal_e   = e_reg.illegal;
  assign stall_req   = (state_reg == BUSY);

endmodule

// File: tb/tb_decode_control_pipe.sv
// Bench for decode_control_pipe: three configurations driven in parallel and checked against a
// rule-level reference model, plus a hand-written vector table and divide/hold/flush sequences.
`timescale 1ns/1ps
module tb_decode_control_pipe;
  import decode_pkg::*;

  localparam int N = 3;  // inst0: M, 4 cycles; inst1: M, 1 cycle; inst2: no M, 4 cycles

  function automatic bit sm_of(input int i);
    return (i != 2);
  endfunction
  function automatic int dc_of(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       as;
    logic [2:0] br;
    logic       j;
    logic [4:0] alu;
    logic       il;
  } e_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       v;
    logic [2:0] imm;
    e_t         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, valid_d, hold_e, flush_e;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic [2:0] imm_o [N];
  logic       rw_o [N];
  logic [1:0] rs_o [N];
  logic       mw_o [N];
  logic       as_o [N];
  logic [2:0] br_o [N];
  logic       j_o [N];
  logic [4:0] alu_o [N];
  logic       il_o [N];
  logic       stall_o [N];

  int checks = 0;
  int errors = 0;
  e_t mdl [N];
  int rem [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    decode_control_pipe #(.SUPPORT_M(gi != 2), .DIV_CYCLES((gi == 1) ? 1 : 4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .valid_d(valid_d), .hold_e(hold_e), .flush_e(flush_e),
      .ImmSrcD(imm_o[gi]), .RegWriteE(rw_o[gi]), .ResultSrcE(rs_o[gi]),
      .MemWriteE(mw_o[gi]), .ALUSrcE(as_o[gi]), .BranchE(br_o[gi]), .JumpE(j_o[gi]),
      .ALUControlE(alu_o[gi]), .illegal_e(il_o[gi]), .stall_req(stall_o[gi])
    );
  end

  function automatic e_t bub();
    e_t b = '0;
    b.br  = 3'b010;
    b.alu = 5'(ADD);
    return b;
  endfunction

  function automatic e_t mk(input logic rw, input logic [1:0] rs, input logic mw, input logic as,
                            input logic [2:0] br, input logic j, input alu_op_t op, input logic il);
    e_t e;
    e.rw = rw; e.rs = rs; e.mw = mw; e.as = as; e.br = br; e.j = j; e.alu = 5'(op); e.il = il;
    return e;
  endfunction

  // Reference decode straight from the ISA rules
  function automatic void ref_dec(input bit sm, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic v,
                                  output e_t e, output logic [2:0] imm, output bit dv);
    logic [4:0] base [8];
    bit legal = 1'b1;
    base = '{5'(ADD), 5'(SLL), 5'(SLT), 5'(SLTU), 5'(XOR), 5'(SRL), 5'(OR), 5'(AND)};
    e = bub(); imm = 3'b000; dv = 1'b0;
    case (op)
      7'b0110011: begin
        e.rw = 1'b1;
        if (f7 == 7'h00) e.alu = base[f3];
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu = (f3 == 3'd0) ? 5'(SUB) : 5'(SRA);
        else if (f7 == 7'h01 && sm) begin e.alu = 5'(MUL) + 5'(f3); dv = (f3 >= 3'd4); end
        else legal = 1'b0;
      end
      7'b0010011: begin
        e.rw = 1'b1; e.as = 1'b1; e.alu = base[f3];
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) e.alu = 5'(SRA);
          else if (f7 != 7'h00) legal = 1'b0;
        end
      end
      7'b0000011: begin e.rw = 1'b1; e.rs = 2'd1; e.as = 1'b1; legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
      7'b0100011: begin e.mw = 1'b1; e.as = 1'b1; imm = 3'd1; legal = (f3 < 3'd3); end
      7'b1100011: begin e.br = f3; e.alu = 5'(SUB); imm = 3'd2; legal = !(f3 inside {3'd2, 3'd3}); end
      7'b1101111: begin e.rw = 1'b1; e.rs = 2'd2; e.j = 1'b1; imm = 3'd4; end
      7'b1100111: begin e.rw = 1'b1; e.rs = 2'd2; e.j = 1'b1; e.as = 1'b1; legal = (f3 == 3'd0); end
      7'b0110111: begin e.rw = 1'b1; e.as = 1'b1; e.alu = 5'(PASSB); imm = 3'd3; end
      7'b0010111: begin e.rw = 1'b1; e.rs = 2'd3; e.as = 1'b1; imm = 3'd3; end
      default: legal = 1'b0;
    endcase
    if (!v || !legal) begin
      e = bub(); e.il = v; imm = 3'b000; dv = 1'b0;
    end
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic v, input logic h, input logic f);
    opcode = op; funct3 = f3; funct7 = f7; valid_d = v; hold_e = h; flush_e = f;
  endtask

  // One clock: check ImmSrcD on the current inputs, advance model and DUTs, check E outputs
  task automatic cycle(input string tag);
    e_t nx [N];
    int nr [N];
    e_t d;
    logic [2:0] imm;
    bit dv;
    #1;
    for (int i = 0; i < N; i++) begin
      ref_dec(sm_of(i), opcode, funct3, funct7, valid_d, d, imm, dv);
      check(imm_o[i] === imm, $sformatf("%s imm inst%0d", tag, i), 32'(imm_o[i]), 32'(imm));
      nx[i] = mdl[i]; nr[i] = rem[i];
      if (rst || flush_e) begin nx[i] = bub(); nr[i] = 0; end
      else if (rem[i] > 0) nr[i] = rem[i] - 1;
      else if (!hold_e) begin
        nx[i] = d;
        if (dv && dc_of(i) > 1) nr[i] = dc_of(i) - 1;
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin mdl[i] = nx[i]; rem[i] = nr[i]; end
    #1;
    for (int i = 0; i < N; i++) begin
      e_t a;
      a = {rw_o[i], rs_o[i], mw_o[i], as_o[i], br_o[i], j_o[i], alu_o[i], il_o[i]};
      check(a === mdl[i], $sformatf("%s E inst%0d", tag, i), 32'(a), 32'(mdl[i]));
      check(stall_o[i] === (rem[i] > 0), $sformatf("%s stall inst%0d", tag, i),
            32'(stall_o[i]), 32'(rem[i] > 0));
    end
  endtask

  function automatic e_t act0();
    return {rw_o[0], rs_o[0], mw_o[0], as_o[0], br_o[0], j_o[0], alu_o[0], il_o[0]};
  endfunction

  vec_t tbl [22];
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, BR = 7'b1100011, JR = 7'b1100111;

  initial begin
    int cnt0, cnt1;
    for (int i = 0; i < N; i++) begin mdl[i] = bub(); rem[i] = 0; end
    tbl[0]  = '{R,  3'd0, 7'h00, 1'b1, 3'd0, mk(1, 0, 0, 0, 3'd2, 0, ADD, 0)};
    tbl[1]  = '{R,  3'd0, 7'h20, 1'b1, 3'd0, mk(1, 0, 0, 0, 3'd2, 0, SUB, 0)};
    tbl[2]  = '{7'b0100011, 3'd2, 7'h00, 1'b1, 3'd1, mk(0, 0, 1, 1, 3'd2, 0, ADD, 0)};
    tbl[3]  = '{7'b0000011, 3'd2, 7'h00, 1'b1, 3'd0, mk(1, 1, 0, 1, 3'd2, 0, ADD, 0)};
    tbl[4]  = '{BR, 3'd0, 7'h00, 1'b1, 3'd2, mk(0, 0, 0, 0, 3'd0, 0, SUB, 0)};
    tbl[5]  = '{BR, 3'd1, 7'h00, 1'b1, 3'd2, mk(0, 0, 0, 0, 3'd1, 0, SUB, 0)};
    tbl[6]  = '{BR, 3'd7, 7'h00, 1'b1, 3'd2, mk(0, 0, 0, 0, 3'd7, 0, SUB, 0)};
    tbl[7]  = '{7'b1101111, 3'd3, 7'h11, 1'b1, 3'd4, mk(1, 2, 0, 0, 3'd2, 1, ADD, 0)};
    tbl[8]  = '{JR, 3'd0, 7'h00, 1'b1, 3'd0, mk(1, 2, 0, 1, 3'd2, 1, ADD, 0)};
    tbl[9]  = '{7'b0110111, 3'd5, 7'h3f, 1'b1, 3'd3, mk(1, 0, 0, 1, 3'd2, 0, PASSB, 0)};
    tbl[10] = '{7'b0010111, 3'd1, 7'h00, 1'b1, 3'd3, mk(1, 3, 0, 1, 3'd2, 0, ADD, 0)};
    tbl[11] = '{I,  3'd5, 7'h20, 1'b1, 3'd0, mk(1, 0, 0, 1, 3'd2, 0, SRA, 0)};
    tbl[12] = '{I,  3'd5, 7'h00, 1'b1, 3'd0, mk(1, 0, 0, 1, 3'd2, 0, SRL, 0)};
    tbl[13] = '{R,  3'd5, 7'h20, 1'b1, 3'd0, mk(1, 0, 0, 0, 3'd2, 0, SRA, 0)};
    tbl[14] = '{R,  3'd0, 7'h01, 1'b1, 3'd0, mk(1, 0, 0, 0, 3'd2, 0, MUL, 0)};
    tbl[15] = '{R,  3'd3, 7'h01, 1'b1, 3'd0, mk(1, 0, 0, 0, 3'd2, 0, MULHU, 0)};
    tbl[16] = '{I,  3'd4, 7'h55, 1'b1, 3'd0, mk(1, 0, 0, 1, 3'd2, 0, XOR, 0)};
    tbl[17] = '{7'b1111111, 3'd0, 7'h00, 1'b1, 3'd0, mk(0, 0, 0, 0, 3'd2, 0, ADD, 1)};
    tbl[18] = '{7'b1111111, 3'd0, 7'h00, 1'b0, 3'd0, mk(0, 0, 0, 0, 3'd2, 0, ADD, 0)};
    tbl[19] = '{R,  3'd1, 7'h20, 1'b1, 3'd0, mk(0, 0, 0, 0, 3'd2, 0, ADD, 1)};
    tbl[20] = '{JR, 3'd1, 7'h00, 1'b1, 3'd0, mk(0, 0, 0, 0, 3'd2, 0, ADD, 1)};
    tbl[21] = '{BR, 3'd2, 7'h00, 1'b1, 3'd0, mk(0, 0, 0, 0, 3'd2, 0, ADD, 1)};

    rst = 1'b1;
    set_in(7'h00, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0);
    cycle("reset0");
    cycle("reset1");
    check(act0() === bub() && stall_o[0] === 1'b0, "reset bubble", 32'(act0()), 32'(bub()));
    rst = 1'b0;
    $display("reset done");

    for (int k = 0; k < 22; k++) begin
      set_in(tbl[k].op, tbl[k].f3, tbl[k].f7, tbl[k].v, 1'b0, 1'b0);
      #1;
      check(imm_o[0] === tbl[k].imm, $sformatf("vec%0d imm", k), 32'(imm_o[0]), 32'(tbl[k].imm));
      cycle($sformatf("vec%0d", k));
      check(act0() === tbl[k].exp, $sformatf("vec%0d table", k), 32'(act0()), 32'(tbl[k].exp));
      $display("vec%0d op=%b f3=%0d f7=%h v=%0b -> E=%h", k, tbl[k].op, tbl[k].f3, tbl[k].f7, tbl[k].v, act0());
    end

    // single divide, hold_e low throughout, next instruction waiting in D
    set_in(R, 3'd4, 7'h01, 1'b1, 1'b0, 1'b0);
    cycle("div_load");
    check(alu_o[0] === 5'(DIV), "div aluctrl", 32'(alu_o[0]), 32'(DIV));
    check(il_o[2] === 1'b1 && rw_o[2] === 1'b0, "div illegal noM", 32'({il_o[2], rw_o[2]}), 32'h2);
    cnt0 = int'(stall_o[0]); cnt1 = int'(stall_o[1]);
    set_in(R, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      cycle("div_run");
      cnt0 += int'(stall_o[0]); cnt1 += int'(stall_o[1]);
    end
    check(cnt0 == 3, "div stall cycles", 32'(cnt0), 32'd3);
    check(cnt1 == 0, "div1 stall cycles", 32'(cnt1), 32'd0);
    $display("div: stall cycles inst0=%0d inst1=%0d", cnt0, cnt1);

    // flush in the second busy cycle
    set_in(R, 3'd6, 7'h01, 1'b1, 1'b0, 1'b0);
    cycle("rem_load");
    set_in(R, 3'd0, 7'h20, 1'b1, 1'b0, 1'b0);
    cycle("rem_busy");
    flush_e = 1'b1;
    cycle("rem_flush");
    check(act0() === bub() && stall_o[0] === 1'b0, "flush in busy", 32'({act0(), stall_o[0]}), 32'({bub(), 1'b0}));
    flush_e = 1'b0;
    cycle("after_flush");
    $display("flush mid-divide done");

    // reset mid-divide
    set_in(R, 3'd5, 7'h01, 1'b1, 1'b0, 1'b0);
    cycle("divu_load");
    rst = 1'b1;
    cycle("divu_rst");
    check(stall_o[0] === 1'b0 && act0() === bub(), "rst in busy", 32'({act0(), stall_o[0]}), 32'({bub(), 1'b0}));
    rst = 1'b0;
    $display("reset mid-divide done");

    // back-to-back divides: D keeps presenting remu
    set_in(R, 3'd7, 7'h01, 1'b1, 1'b0, 1'b0);
    cycle("b2b_load");
    cnt0 = int'(stall_o[0]);
    for (int c = 0; c < 7; c++) begin
      cycle("b2b_run");
      cnt0 += int'(stall_o[0]);
    end
    check(cnt0 == 6, "b2b stall cycles", 32'(cnt0), 32'd6);
    $display("back-to-back divide stall cycles=%0d", cnt0);
    set_in(R, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) cycle("drain");

    // hold keeps beq; hold with flush bubbles
    set_in(BR, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
    cycle("beq_load");
    set_in(R, 3'd0, 7'h00, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      cycle("beq_hold");
      check(br_o[0] === 3'b000, "beq held", 32'(br_o[0]), 32'd0);
    end
    flush_e = 1'b1;
    cycle("hold_flush");
    check(br_o[0] === 3'b010 && act0() === bub(), "flush beats hold", 32'(act0()), 32'(bub()));
    $display("hold/flush sequence done");

    // randomized traffic against the reference model
    for (int t = 0; t < 400; t++) begin
      logic [6:0] ops [10];
      logic [6:0] f7s [4];
      ops = '{R, I, 7'b0000011, 7'b0100011, BR, 7'b1101111, JR, 7'b0110111, 7'b0010111, 7'($urandom)};
      f7s = '{7'h00, 7'h20, 7'h01, 7'($urandom)};
      rst = ($urandom_range(0, 99) < 2);
      set_in(ops[$urandom_range(0, 9)], 3'($urandom), f7s[$urandom_range(0, 3)],
             ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5));
      cycle($sformatf("rand%0d", t));
      $display("rand%0d op=%b f3=%0d f7=%h v=%0b h=%0b f=%0b r=%0b E0=%h stall=%0b%0b%0b", t, opcode,
               funct3, funct7, valid_d, hold_e, flush_e, rst, act0(), stall_o[0], stall_o[1], stall_o[2]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_control_pipe.md
Name: decode_control_pipe

Overview:
- Parametrised successor to the decode-stage control unit for the pipelined RV32I core.
- Combinationally decodes opcode/funct3/funct7 into the control bundle and drives ImmSrcD to the D-stage extend unit.
- Registers the rest of the bundle into the E stage with hold/flush.
- Adds optional RV32M decode and a multi-cycle divide sequencer that holds E and requests a front-end stall.

Parameters:
- SUPPORT_M, 1, 1 = decode RV32M (opcode 0110011, funct7 0000001); 0 = such encodings are illegal.
- DIV_CYCLES, 4, E-stage occupancy of DIV/DIVU/REM/REMU in cycles; legal range 1..15.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- opcode  input  7  instr[6:0], D stage
- funct3  input  3  instr[14:12]
- funct7  input  7  instr[31:25]
- valid_d  input  1  D holds a real instruction
- hold_e  input  1  hazard unit: keep E register
- flush_e  input  1  hazard unit: insert bubble into E
- ImmSrcD  output  3  combinational: 000 I, 001 S, 010 B, 011 U, 100 J
- RegWriteE  output  1  registered
- ResultSrcE  output  2  00 ALU, 01 mem, 10 PC+4, 11 PC+imm (AUIPC)
- MemWriteE  output  1
- ALUSrcE  output  1  1 = immediate operand
- BranchE  output  3  funct3 of branch; 3'b010 when not a branch (reserved, no-branch)
- JumpE  output  1
- ALUControlE  output  5  ALU/MDU op code from pkg
- illegal_e  output  1  E holds an illegal valid instruction
- stall_req  output  1  divide busy, stall F/D

Behaviour:
- Decode is combinational.
  - R/I-ALU: funct7[5] selects SUB (R only) and SRA.
  - LUI: ALU op PASSB.
  - Loads: ResultSrc 01.
  - Stores: MemWrite 1.
  - JAL/JALR: Jump 1, ResultSrc 10.
  - Unsupported opcode or funct combination with valid_d=1: bundle zeroed (no writes), illegal=1.
  - valid_d=0: bundle zeroed, illegal=0.
- E register update priority: rst > flush_e > internal div hold > hold_e > load from D.
  - Bubble and reset value: all E outputs 0, BranchE=3'b010, ALUControlE=ADD.
- Latency: D decode appears on E outputs one clk edge later.
- Divide FSM, states IDLE/BUSY, 4-bit counter cnt.
  - IDLE -> BUSY when a div/rem op is loaded into E and DIV_CYCLES>1; cnt := DIV_CYCLES-2.
  - In BUSY: stall_req=1 and the E register holds regardless of hold_e.
  - BUSY with cnt==0 -> IDLE; otherwise cnt decrements.
  - Result: stall_req high for exactly DIV_CYCLES-1 cycles, starting the cycle after load.
  - DIV_CYCLES=1: FSM never leaves IDLE, stall_req never asserts.
  - flush_e in BUSY: E bubbled, FSM -> IDLE same edge, stall_req low next cycle.
  - rst mid-divide: IDLE, cnt=0, stall_req=0.
  - Back-to-back divides: the second loads only after IDLE; the new BUSY starts on that load.
- MUL/MULH/MULHSU/MULHU are single-cycle; no stall.
- stall_req is combinational from state only (state==BUSY), glitch-free.
- Reset values: all registered outputs as bubble; stall_req 0.

Decomposition:
- Package decode_pkg:
  - ALU_CTRL_W=5.
  - Enum alu_op_t: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - ImmSrc and ResultSrc localparams.
  - Struct ctrl_bundle_t.
- Sub-module: control_decode (pure combinational opcode/funct -> ctrl_bundle_t, parametrised on SUPPORT_M).
- Top holds the E register and divide FSM.

Test Plan:
- Reset: rst=1 for 2 cycles -> all E outputs bubble, BranchE=010, stall_req=0.
- add (0110011, f3 000, f7 0000000), then sub (f7 0100000) on consecutive cycles -> ALUControlE=ADD then SUB, RegWriteE=1 each, one-cycle latency; sw (0100011) -> MemWriteE=1, RegWriteE=0, ImmSrcD=001 same cycle.
- SUPPORT_M=1, DIV_CYCLES=4, issue div (f7 0000001, f3 100) -> ALUControlE=DIV; stall_req=1 for exactly 3 cycles; E outputs stable throughout even with hold_e=0; next D instruction appears the cycle after stall_req falls.
- Same divide, flush_e asserted in 2nd busy cycle -> next edge E=bubble, stall_req=0 one cycle later, FSM IDLE.
- SUPPORT_M=0, issue mul -> illegal_e=1, RegWriteE=0; opcode 1111111 with valid_d=1 -> illegal_e=1; same with valid_d=0 -> illegal_e=0.
- hold_e=1 for 2 cycles after beq (f3 000) in E -> BranchE=000 held; hold_e with flush_e both high -> bubble (flush wins).
